// File: rtl/fp8_mul_arbiter.sv
// Shared FP8 (E4M3, bias 7) multiplier: 0x80 is NaN, no infinities, saturates to +/-0x7F.
// Latency: purely combinational, no state.
// Backpressure: none; the result follows the operands in the same cycle.
module fp8mul (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);

  logic        sign;
  logic [3:0]  sig_a, sig_b, exp_a, exp_b;
  logic [7:0]  prod, norm;
  logic [2:0]  lead;
  logic [5:0]  e_raw, sh, e_clamp;
  logic [23:0] shifted;
  logic        rnd;
  logic [4:0]  rounded;
  logic [9:0]  mag;

  // Multiply significands, normalise, round to nearest-even (subnormals kept), saturate
  always_comb begin
    sign  = a[7] ^ b[7];
    exp_a = (a[6:3] == 4'd0) ? 4'd1 : a[6:3];
    exp_b = (b[6:3] == 4'd0) ? 4'd1 : b[6:3];
    sig_a = {(a[6:3] != 4'd0), a[2:0]};
    sig_b = {(b[6:3] != 4'd0), b[2:0]};
    prod  = {4'd0, sig_a} * {4'd0, sig_b};
    lead  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (prod[i]) lead = i[2:0];
    end
    norm  = prod << (3'd7 - lead);
    // Biased result exponent is e_raw - 13; below 1 the value is subnormal
    e_raw = {3'd0, lead} + {2'd0, exp_a} + {2'd0, exp_b};
    if (e_raw >= 6'd14) begin
      sh      = 6'd0;
      e_clamp = e_raw - 6'd13;
    end else begin
      sh      = 6'd14 - e_raw;
      e_clamp = 6'd1;
    end
    // 16 spare low bits: the largest subnormal shift (12) never drops a set bit
    shifted = {norm, 16'h0000} >> sh;
    rnd     = shifted[19] & ((|shifted[18:0]) | shifted[20]);
    rounded = {1'b0, shifted[23:20]} + {4'd0, rnd};
    // Exponent*8 + significand - hidden one: carries out of the mantissa land correctly
    mag     = {1'b0, e_clamp, 3'b000} + {5'd0, rounded} - 10'd8;
    if (a == 8'h80 || b == 8'h80) begin
      p = 8'h80;
    end else if (prod == 8'd0 || mag == 10'd0) begin
      p = 8'h00;
    end else if (mag > 10'd127) begin
      p = {sign, 7'h7F};
    end else begin
      p = {sign, mag[6:0]};
    end
  end

endmodule

// Two-requester arbiter sharing one fp8mul; round-robin or fixed priority to requester 0.
// Latency: accept at edge N, rsp_valid after edge N+1; one transaction in flight.
// Backpressure: result held in RESP until rsp_ready; no request accepted while busy.
module fp8_mul_arbiter #(
  parameter int unsigned FAIR_RR = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_id,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE = 2'b00, EXEC = 2'b01, RESP = 2'b10} state_t;

  state_t     state, state_nxt;
  logic [7:0] op_a, op_b, mul_p;
  logic       owner, last_grant, grant, hs;

  fp8mul u_mul (.a(op_a), .b(op_b), .p(mul_p));

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // Grant selection, ready generation and next-state decode
  always_comb begin
    grant      = 1'b0;
    hs         = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    state_nxt  = state;
    if (FAIR_RR != 0) begin
      grant = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    end else begin
      grant = ~req0_valid & req1_valid;
    end
    case (state)
      IDLE: begin
        req0_ready = ~grant;
        req1_ready = grant;
        hs         = grant ? req1_valid : req0_valid;
        if (hs) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Capture operands and owner on accept; last_grant only moves on a real handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a       <= 8'h00;
      op_b       <= 8'h00;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else if (hs) begin
      op_a       <= grant ? req1_a : req0_a;
      op_b       <= grant ? req1_b : req0_b;
      owner      <= grant;
      last_grant <= grant;
    end
  end

  // Register the product and its owner when leaving EXEC; held through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= 8'h00;
      rsp_id   <= 1'b0;
    end else if (state == EXEC) begin
      rsp_data <= mul_p;
      rsp_id   <= owner;
    end
  end

endmodule

// File: tb/tb_fp8_mul_arbiter.sv
// Bench for fp8_mul_arbiter: directed steps on a round-robin and a fixed-priority
// instance, then randomized traffic against a transaction-level reference model.
module tb_fp8_mul_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       r0_valid, r0_ready, r1_valid, r1_ready;
  logic [7:0] r0_a, r0_b, r1_a, r1_b;
  logic       r_rsp_valid, r_rsp_ready, r_rsp_id, r_busy;
  logic [7:0] r_rsp_data;
  logic       f0_valid, f0_ready, f1_valid, f1_ready;
  logic [7:0] f0_a, f0_b, f1_a, f1_b;
  logic       f_rsp_valid, f_rsp_ready, f_rsp_id, f_busy;
  logic [7:0] f_rsp_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  fp8_mul_arbiter #(.FAIR_RR(1)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0_valid), .req0_ready(r0_ready), .req0_a(r0_a), .req0_b(r0_b),
    .req1_valid(r1_valid), .req1_ready(r1_ready), .req1_a(r1_a), .req1_b(r1_b),
    .rsp_valid(r_rsp_valid), .rsp_ready(r_rsp_ready), .rsp_data(r_rsp_data),
    .rsp_id(r_rsp_id), .busy(r_busy)
  );

  fp8_mul_arbiter #(.FAIR_RR(0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(f0_valid), .req0_ready(f0_ready), .req0_a(f0_a), .req0_b(f0_b),
    .req1_valid(f1_valid), .req1_ready(f1_ready), .req1_a(f1_a), .req1_b(f1_b),
    .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_data(f_rsp_data),
    .rsp_id(f_rsp_id), .busy(f_busy)
  );

  typedef struct {
    logic       id;
    logic [7:0] dat;
  } exp_t;

  exp_t pend[$];

  // Real value of an FP8 code (0x80 excluded by callers)
  function automatic real fp8_val(input logic [7:0] c);
    real s, m;
    int  mi;
    s  = 1.0 / 1024.0;
    for (int k = 0; k < 15; k++) if (k < int'(c[6:3])) s = s * 2.0;
    mi = int'(c[2:0]);
    if (c[6:3] == 4'd0) m = 2.0 * mi;
    else                m = 8.0 + mi;
    return c[7] ? -(m * s) : (m * s);
  endfunction

  // Exact product, then nearest finite code (ties to even code); saturation falls out
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    real        v, bd;
    logic [7:0] best;
    if (a == 8'h80 || b == 8'h80) return 8'h80;
    v    = fp8_val(a) * fp8_val(b);
    best = 8'h00;
    bd   = (v < 0.0) ? -v : v;
    for (int i = 1; i < 256; i++) begin
      logic [7:0] c;
      real        d;
      c = 8'(i);
      if (c != 8'h80) begin
        d = v - fp8_val(c);
        if (d < 0.0) d = -d;
        if (d < bd || (d == bd && !c[0])) begin
          best = c;
          bd   = d;
        end
      end
    end
    return best;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_r(input string tag);
    int n = 0;
    while (r_rsp_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk1({tag, "_rsp_seen"}, r_rsp_valid, 1'b1);
  endtask

  task automatic wait_f(input string tag);
    int n = 0;
    while (f_rsp_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk1({tag, "_rsp_seen"}, f_rsp_valid, 1'b1);
  endtask

  task automatic run_op(input string tag, input logic id, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp);
    if (id) begin r1_a = a; r1_b = b; r1_valid = 1'b1; end
    else    begin r0_a = a; r0_b = b; r0_valid = 1'b1; end
    r_rsp_ready = 1'b1;
    tick();
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    wait_r(tag);
    chk(tag, r_rsp_data, exp);
    chk1({tag, "_id"}, r_rsp_id, id);
    tick();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   last_cyc;
    logic exp_id[3];
    logic [7:0] exp_dat[3];
    logic last_m, g, idle_m;
    int   age;

    rst_n = 1'b0;
    {r0_valid, r1_valid, r_rsp_ready, f0_valid, f1_valid, f_rsp_ready} = '0;
    {r0_a, r0_b, r1_a, r1_b, f0_a, f0_b, f1_a, f1_b} = '0;
    #2;
    // Reset state
    chk1("rst_rsp_valid", r_rsp_valid, 1'b0);
    chk1("rst_busy", r_busy, 1'b0);
    chk("rst_rsp_data", r_rsp_data, 8'h00);
    chk1("rst_rsp_id", r_rsp_id, 1'b0);
    chk1("rst_req0_ready", r0_ready, 1'b1);
    chk1("rst_req1_ready", r1_ready, 1'b0);
    chk1("rst_fp_busy", f_busy, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single multiply 1.5 * 2.0
    r0_a = 8'h3C; r0_b = 8'h40; r0_valid = 1'b1; r_rsp_ready = 1'b1;
    #1;
    chk1("single_req0_ready", r0_ready, 1'b1);
    chk1("single_req1_ready", r1_ready, 1'b0);
    tick();
    r0_valid = 1'b0;
    #1;
    chk1("exec_busy", r_busy, 1'b1);
    chk1("exec_rsp_valid", r_rsp_valid, 1'b0);
    chk1("exec_req0_ready", r0_ready, 1'b0);
    tick();
    chk1("single_rsp_valid", r_rsp_valid, 1'b1);
    chk("single_rsp_data", r_rsp_data, 8'h44);
    chk1("single_rsp_id", r_rsp_id, 1'b0);
    tick();
    chk1("single_after_valid", r_rsp_valid, 1'b0);
    chk1("single_after_busy", r_busy, 1'b0);

    // Special values and rounding corners
    run_op("nan", 1'b0, 8'h80, 8'h38, 8'h80);
    run_op("zero", 1'b0, 8'h00, 8'h38, 8'h00);
    run_op("saturate", 1'b0, 8'h78, 8'h78, 8'h7F);
    run_op("neg_one", 1'b0, 8'hB8, 8'h38, 8'hB8);
    run_op("neg_saturate", 1'b0, 8'hF8, 8'h78, 8'hFF);
    run_op("subnormal", 1'b0, 8'h01, 8'h38, 8'h01);
    run_op("underflow", 1'b0, 8'h08, 8'h08, 8'h00);
    run_op("sub_to_norm", 1'b0, 8'h04, 8'h40, 8'h08);

    // Backpressure in RESP with another request waiting
    r_rsp_ready = 1'b0;
    r0_a = 8'h3C; r0_b = 8'h40; r0_valid = 1'b1;
    tick();
    r0_valid = 1'b0;
    r1_a = 8'h40; r1_b = 8'h40; r1_valid = 1'b1;
    wait_r("bp");
    for (int i = 0; i < 5; i++) begin
      chk1("bp_rsp_valid", r_rsp_valid, 1'b1);
      chk("bp_rsp_data", r_rsp_data, 8'h44);
      chk1("bp_req0_ready", r0_ready, 1'b0);
      chk1("bp_req1_ready", r1_ready, 1'b0);
      tick();
    end
    r_rsp_ready = 1'b1;
    tick();
    chk1("bp_release_valid", r_rsp_valid, 1'b0);
    chk1("bp_release_busy", r_busy, 1'b0);
    chk1("bp_release_req1_ready", r1_ready, 1'b1);
    r1_valid = 1'b0;
    tick();
    chk1("drop_no_accept", r_busy, 1'b0);

    // Reset mid-operation discards the transaction
    run_op("req1_op", 1'b1, 8'h40, 8'h3C, 8'h44);
    r0_a = 8'h3C; r0_b = 8'h3C; r0_valid = 1'b1;
    tick();
    r0_valid = 1'b0;
    chk1("mid_exec_busy", r_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_valid", r_rsp_valid, 1'b0);
    chk1("mid_rst_busy", r_busy, 1'b0);
    chk("mid_rst_data", r_rsp_data, 8'h00);
    chk1("mid_rst_id", r_rsp_id, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk1("post_rst_no_valid", r_rsp_valid, 1'b0);
      tick();
    end
    r0_a = 8'h38; r0_b = 8'h40; r0_valid = 1'b1;
    #1;
    chk1("post_rst_ready", r0_ready, 1'b1);
    tick();
    r0_valid = 1'b0;
    chk1("post_rst_first_accept", r_busy, 1'b1);
    wait_r("post_rst");
    chk("post_rst_data", r_rsp_data, 8'h40);
    tick();

    // Round-robin tie out of reset
    pulse_reset();
    exp_id  = '{1'b0, 1'b1, 1'b0};
    exp_dat = '{8'h38, 8'h48, 8'h38};
    r0_a = 8'h38; r0_b = 8'h38; r1_a = 8'h40; r1_b = 8'h40;
    r0_valid = 1'b1; r1_valid = 1'b1; r_rsp_ready = 1'b1;
    last_cyc = 0;
    for (int k = 0; k < 3; k++) begin
      wait_r("rr");
      chk1("rr_id", r_rsp_id, exp_id[k]);
      chk("rr_data", r_rsp_data, exp_dat[k]);
      if (k > 0) chk("rr_interval", 8'(cyc - last_cyc), 8'd3);
      last_cyc = cyc;
      tick();
    end
    r0_valid = 1'b0; r1_valid = 1'b0;

    // Fixed priority: requester 1 starves until requester 0 drops
    f0_a = 8'h38; f0_b = 8'h40; f1_a = 8'h40; f1_b = 8'h40;
    f0_valid = 1'b1; f1_valid = 1'b1; f_rsp_ready = 1'b1;
    #1;
    chk1("fp_req1_ready", f1_ready, 1'b0);
    chk1("fp_req0_ready", f0_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      wait_f("fp");
      chk1("fp_id", f_rsp_id, 1'b0);
      chk("fp_data", f_rsp_data, 8'h40);
      tick();
    end
    f0_valid = 1'b0;
    wait_f("fp_req1");
    chk1("fp_req1_id", f_rsp_id, 1'b1);
    chk("fp_req1_data", f_rsp_data, 8'h48);
    f1_valid = 1'b0;
    tick();

    // Randomized traffic against the transaction-level model
    pulse_reset();
    last_m = 1'b1;
    age    = 0;
    pend.delete();
    for (int n = 0; n < 400; n++) begin
      r0_valid    = 1'($urandom_range(0, 1));
      r1_valid    = 1'($urandom_range(0, 1));
      r0_a        = 8'($urandom);
      r0_b        = 8'($urandom);
      r1_a        = 8'($urandom);
      r1_b        = 8'($urandom);
      r_rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      idle_m = (pend.size() == 0);
      g      = (r0_valid && r1_valid) ? !last_m : r1_valid;
      chk1("rnd_req0_ready", r0_ready, idle_m && !g);
      chk1("rnd_req1_ready", r1_ready, idle_m && g);
      chk1("rnd_busy", r_busy, !idle_m);
      chk1("rnd_rsp_valid", r_rsp_valid, !idle_m && age >= 1);
      if (!idle_m && age >= 1) begin
        chk("rnd_rsp_data", r_rsp_data, pend[0].dat);
        chk1("rnd_rsp_id", r_rsp_id, pend[0].id);
      end
      if (idle_m && (g ? r1_valid : r0_valid)) begin
        pend.push_back('{id: g, dat: g ? ref_mul(r1_a, r1_b) : ref_mul(r0_a, r0_b)});
        age    = 0;
        last_m = g;
      end else if (!idle_m) begin
        if (age >= 1 && r_rsp_ready) void'(pend.pop_front());
        age++;
      end
      tick();
    end
    r0_valid = 1'b0; r1_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
